// File: rtl/rtc_display_reader.sv
// Seven-segment bus monitor: filters the six RTC digit patterns, decodes them to BCD and
// checks that each committed time is exactly one second after the previous one.
module rtc_display_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [41:0]          sev_seg,
  input  logic                 chk_en,
  output logic [23:0]          time_bcd,
  output logic                 valid,
  output logic                 upd,
  output logic                 pat_err,
  output logic                 range_err,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 1);

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_e;

  // state_q is the observable FSM state for bound checkers
  state_e state_q, state_d, cur_state;

  logic [41:0]          samp_q;
  logic [7:0]           stab_cnt_q, stab_cnt_d;
  logic                 chk_q;
  logic [23:0]          time_q, time_d, exp_q, exp_d;
  logic                 valid_q, valid_d;
  logic                 upd_q, upd_d, pat_err_q, pat_err_d;
  logic                 range_err_q, range_err_d, seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        same, commit, chk_rise, pat_bad, range_bad, any_err;
  logic [23:0] dec_bcd;

  // Returns {bad, bcd}; segments are active-low gfedcba.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: seg_decode = 5'h00;
      7'b1111001: seg_decode = 5'h01;
      7'b0100100: seg_decode = 5'h02;
      7'b0110000: seg_decode = 5'h03;
      7'b0011001: seg_decode = 5'h04;
      7'b0010010: seg_decode = 5'h05;
      7'b0000010: seg_decode = 5'h06;
      7'b1111000: seg_decode = 5'h07;
      7'b0000000: seg_decode = 5'h08;
      7'b0010000: seg_decode = 5'h09;
      default:    seg_decode = 5'h10;
    endcase
  endfunction

  function automatic logic [23:0] bcd_succ(input logic [23:0] t);
    logic [3:0] s0, s1, m0, m1, h0, h1;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          if (m1 != 4'd5) m1 = m1 + 4'd1;
          else begin
            m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
              h1 = 4'd0;
              h0 = 4'd0;
            end else if (h0 == 4'd9) begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end else h0 = h0 + 4'd1;
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  // At a commit sev_seg equals samp_q, so decoding the register keeps the path short.
  always_comb begin : decode
    logic [4:0] d;
    d       = '0;
    dec_bcd = '0;
    pat_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d                 = seg_decode(samp_q[7*i +: 7]);
      dec_bcd[4*i +: 4] = d[3:0];
      pat_bad           = pat_bad | d[4];
    end
  end

  assign range_bad = (dec_bcd[7:4] > 4'd5) || (dec_bcd[15:12] > 4'd5) ||
                     (dec_bcd[23:20] > 4'd2) ||
                     (dec_bcd[23:20] == 4'd2 && dec_bcd[19:16] > 4'd3);

  assign same       = (sev_seg == samp_q);
  assign commit     = same && (stab_cnt_q == STAB_PRE);
  assign stab_cnt_d = !same ? 8'd0 : (stab_cnt_q == STAB_MAX) ? STAB_MAX : stab_cnt_q + 8'd1;
  assign chk_rise   = chk_en & ~chk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      samp_q      <= '1;
      stab_cnt_q  <= '0;
      chk_q       <= 1'b0;
      time_q      <= '0;
      exp_q       <= '0;
      valid_q     <= 1'b0;
      upd_q       <= 1'b0;
      pat_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      samp_q      <= sev_seg;
      stab_cnt_q  <= stab_cnt_d;
      chk_q       <= chk_en;
      time_q      <= time_d;
      exp_q       <= exp_d;
      valid_q     <= valid_d;
      upd_q       <= upd_d;
      pat_err_q   <= pat_err_d;
      range_err_q <= range_err_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // A chk_en rising edge forces SYNC before any same-cycle commit is evaluated.
  always_comb begin
    cur_state = chk_rise ? SYNC : state_q;
    state_d   = cur_state;
    if (commit) state_d = (pat_bad || range_bad) ? SYNC : TRACK;
  end

  always_comb begin
    time_d      = time_q;
    exp_d       = exp_q;
    valid_d     = chk_rise ? 1'b0 : valid_q;
    upd_d       = 1'b0;
    pat_err_d   = 1'b0;
    range_err_d = 1'b0;
    seq_err_d   = 1'b0;
    if (commit) begin
      upd_d = 1'b1;
      if (pat_bad) begin
        pat_err_d = 1'b1;
        valid_d   = 1'b0;
      end else if (range_bad) begin
        range_err_d = 1'b1;
        time_d      = dec_bcd;
        valid_d     = 1'b0;
      end else begin
        time_d    = dec_bcd;
        exp_d     = bcd_succ(dec_bcd);
        valid_d   = 1'b1;
        seq_err_d = (cur_state == TRACK) && chk_en && (dec_bcd != exp_q);
      end
    end
    any_err   = pat_err_d | range_err_d | seq_err_d;
    err_cnt_d = (any_err && err_cnt_q != '1) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
  end

  assign time_bcd  = time_q;
  assign valid     = valid_q;
  assign upd       = upd_q;
  assign pat_err   = pat_err_q;
  assign range_err = range_err_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rtc_display_reader.sv
// Bench for rtc_display_reader: directed test-plan steps followed by random time steps,
// every cycle compared against a seconds-of-day reference model.
module tb_rtc_display_reader;

  localparam int STABLE = 4;
  localparam int ECW    = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [41:0]    sev_seg;
  logic           chk_en;
  logic [23:0]    time_bcd;
  logic           valid, upd, pat_err, range_err, seq_err;
  logic [ECW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  logic [41:0]    m_run_pat;
  int             m_run_len;
  logic           m_prev_chk, m_track, m_valid;
  logic [23:0]    m_time;
  int             m_exp;
  logic [ECW-1:0] m_err;
  logic [3:0]     m_pulse;  // {upd, pat_err, range_err, seq_err}

  rtc_display_reader #(.STABLE_CYCLES(STABLE), .ERR_CNT_W(ECW)) dut (
    .clk(clk), .rst(rst), .sev_seg(sev_seg), .chk_en(chk_en),
    .time_bcd(time_bcd), .valid(valid), .upd(upd), .pat_err(pat_err),
    .range_err(range_err), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc_digit(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] enc_time(input int h, input int m, input int s);
    return {enc_digit(h / 10), enc_digit(h % 10), enc_digit(m / 10),
            enc_digit(m % 10), enc_digit(s / 10), enc_digit(s % 10)};
  endfunction

  function automatic logic [41:0] with_sec0(input logic [41:0] p, input logic [6:0] seg);
    logic [41:0] r;
    r      = p;
    r[6:0] = seg;
    return r;
  endfunction

  task automatic model_reset();
    m_run_pat  = '1;
    m_run_len  = 1;
    m_prev_chk = 1'b0;
    m_track    = 1'b0;
    m_valid    = 1'b0;
    m_time     = '0;
    m_exp      = 0;
    m_err      = '0;
    m_pulse    = '0;
  endtask

  task automatic model_commit(input logic [41:0] p);
    int  dg[6];
    int  hh, mm, ss, secs;
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dg[i] = -1;
      for (int d = 0; d < 10; d++)
        if (p[7*i +: 7] == enc_digit(d)) dg[i] = d;
      if (dg[i] < 0) bad = 1'b1;
    end
    m_pulse[3] = 1'b1;
    if (bad) begin
      m_pulse[2] = 1'b1;
      m_valid    = 1'b0;
      m_track    = 1'b0;
    end else begin
      hh     = dg[5] * 10 + dg[4];
      mm     = dg[3] * 10 + dg[2];
      ss     = dg[1] * 10 + dg[0];
      m_time = {4'(dg[5]), 4'(dg[4]), 4'(dg[3]), 4'(dg[2]), 4'(dg[1]), 4'(dg[0])};
      if (dg[3] > 5 || dg[1] > 5 || hh > 23) begin
        m_pulse[1] = 1'b1;
        m_valid    = 1'b0;
        m_track    = 1'b0;
      end else begin
        secs = hh * 3600 + mm * 60 + ss;
        if (m_track && chk_en && secs != m_exp) m_pulse[0] = 1'b1;
        m_valid = 1'b1;
        m_track = 1'b1;
        m_exp   = (secs + 1) % 86400;
      end
    end
    if (m_pulse[2:0] != 3'b000 && m_err != '1) m_err = m_err + ECW'(1);
  endtask

  // Called right at the clock edge with the inputs the DUT just sampled.
  task automatic model_edge();
    m_pulse = '0;
    if (rst) begin
      model_reset();
      return;
    end
    if (sev_seg == m_run_pat) m_run_len++;
    else begin
      m_run_pat = sev_seg;
      m_run_len = 1;
    end
    if (chk_en && !m_prev_chk) begin
      m_track = 1'b0;
      m_valid = 1'b0;
    end
    m_prev_chk = chk_en;
    if (m_run_len == STABLE + 1) model_commit(sev_seg);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    checks++;
    assert ({upd, pat_err, range_err, seq_err} === m_pulse) else begin
      errors++;
      $error("FAIL pulses cyc=%0d got=%b exp=%b", cyc, {upd, pat_err, range_err, seq_err}, m_pulse);
    end
    checks++;
    assert ({valid, time_bcd, err_cnt} === {m_valid, m_time, m_err}) else begin
      errors++;
      $error("FAIL state cyc=%0d got valid=%b time=%h err=%0d exp valid=%b time=%h err=%0d",
             cyc, valid, time_bcd, err_cnt, m_valid, m_time, m_err);
    end
  endtask

  task automatic hold(input logic [41:0] p, input int n);
    sev_seg = p;
    repeat (n) tick();
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    int h, m, s, cur;
    logic [41:0] p;
    model_reset();
    rst     = 1'b1;
    chk_en  = 1'b1;
    sev_seg = enc_time(12, 34, 56);

    // reset and first commit
    tick();
    tick();
    check_val("reset_time", 32'(time_bcd), 32'h0);
    check_val("reset_flags", {valid, upd, pat_err, range_err, seq_err, 8'(err_cnt)}, 32'h0);
    rst = 1'b0;
    repeat (8) tick();
    check_val("first_time", 32'(time_bcd), 32'h123456);
    check_val("first_valid", 32'(valid), 32'h1);

    // sequence through midnight
    chk_en = 1'b0;
    hold(enc_time(23, 59, 58), 10);
    chk_en = 1'b1;
    hold(enc_time(23, 59, 59), 10);
    hold(enc_time(0, 0, 0), 10);
    check_val("wrap_time", 32'(time_bcd), 32'h000000);
    check_val("wrap_err", 32'(err_cnt), 32'd0);

    // skip detection
    chk_en = 1'b0;
    hold(enc_time(9, 59, 59), 10);
    chk_en = 1'b1;
    hold(enc_time(10, 0, 0), 10);
    hold(enc_time(10, 0, 2), 10);
    check_val("skip_err", 32'(err_cnt), 32'd1);
    hold(enc_time(10, 0, 3), 10);
    check_val("after_skip_err", 32'(err_cnt), 32'd1);

    // manual mode, then re-sync on chk_en rise
    chk_en = 1'b0;
    hold(enc_time(10, 0, 0), 10);
    hold(enc_time(15, 27, 0), 10);
    check_val("manual_time", 32'(time_bcd), 32'h152700);
    chk_en  = 1'b1;
    sev_seg = enc_time(15, 27, 1);
    tick();
    check_val("rise_valid_drop", 32'(valid), 32'h0);
    repeat (9) tick();
    check_val("resync_valid", 32'(valid), 32'h1);
    check_val("resync_err", 32'(err_cnt), 32'd1);

    // glitch, then a bad pattern
    hold(enc_time(15, 27, 8), 3);
    check_val("glitch_time", 32'(time_bcd), 32'h152701);
    hold(enc_time(15, 27, 2), 10);
    hold(with_sec0(enc_time(15, 27, 3), 7'b0111111), 10);
    check_val("pat_time_hold", 32'(time_bcd), 32'h152702);
    check_val("pat_valid", 32'(valid), 32'h0);

    // range error and counter saturation
    hold(enc_time(25, 0, 0), 10);
    check_val("range_time", 32'(time_bcd), 32'h250000);
    for (int i = 0; i < 300; i++)
      hold(with_sec0(enc_time(0, 0, 0), (i % 2 == 0) ? 7'b1111111 : 7'b0111111), 6);
    check_val("err_saturated", 32'(err_cnt), 32'hFF);

    // reset in the middle of the filter window
    sev_seg = enc_time(1, 2, 3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midreset_err", 32'(err_cnt), 32'd0);
    hold(enc_time(1, 2, 3), 8);
    check_val("post_reset_time", 32'(time_bcd), 32'h010203);

    // random stepping: successors, jumps, short glitches, chk_en toggles
    h = 1; m = 2; s = 3;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        cur = ((h * 3600 + m * 60 + s) + 1) % 86400;
        h   = cur / 3600;
        m   = (cur / 60) % 60;
        s   = cur % 60;
      end else begin
        h = $urandom_range(0, 25);
        m = $urandom_range(0, 59);
        s = $urandom_range(0, 59);
      end
      p = enc_time(h, m, s);
      if ($urandom_range(0, 9) == 0) p = with_sec0(p, 7'($urandom));
      if ($urandom_range(0, 7) == 0) chk_en = ~chk_en;
      hold(p, $urandom_range(1, 9));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_display_reader.md
# rtc_display_reader

Monitor block for the far end of the RTC seven-segment bus. It samples the six digit patterns that the RTC driver presents to the displays and filters out transient patterns. It decodes each digit back to BCD and checks that every new displayed time is exactly one second later than the previous one. It sits beside the display pins, in the FPGA self-check build and in benches, and reports a decoded time, a valid flag and error events.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is committed; legal values are 1 to 255.
- ERR_CNT_W, 8: width of the saturating error counter.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- sev_seg  in  42  six digit patterns. Bits [7i+6:7i] hold digit i, where i=0 sec0, 1 sec1, 2 min0, 3 min1, 4 hr0, 5 hr1. Within a digit, bit6=g and bit0=a. Segments are active-low.
- chk_en  in  1  enables the sequence check. It is driven low while the RTC is in manual-set mode.
- time_bcd  out  24  committed time as {hr1,hr0,min1,min0,sec1,sec0}, 4 bits per digit.
- valid  out  1  time_bcd holds an in-range, sequence-tracked time.
- upd  out  1  one-cycle pulse: new pattern committed.
- pat_err  out  1  one-cycle pulse: unrecognised segment pattern.
- range_err  out  1  one-cycle pulse: decoded time is out of range.
- seq_err  out  1  one-cycle pulse: committed time is not the expected successor.
- err_cnt  out  ERR_CNT_W  saturating count of all error pulses.

## Operation
- **Digit decode** (active-low, gfedcba):
  - 0=1000000
  - 1=1111001
  - 2=0100100
  - 3=0110000
  - 4=0011001
  - 5=0010010
  - 6=0000010
  - 7=1111000
  - 8=0000000
  - 9=0010000
  - Any other pattern, including blank 1111111, is a pattern error.
- **Stability filter:**
  - samp_q <= sev_seg on every edge.
  - stab_cnt <= (sev_seg==samp_q) ? min(stab_cnt+1, STABLE_CYCLES) : 0.
  - A commit fires on the edge where stab_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES with sev_seg==samp_q.
  - Exactly one commit occurs per stable value.
- **Range rules:** sec1<=5, min1<=5, hours 00–23.
- **Successor rule:**
  - sec0 9->0 carries into sec1; sec1 5->0 carries into min0. Minutes carry the same way into the hours.
  - Hours 23 wrap to 00, so 23:59:59 -> 00:00:00.
  - 09->10 and 19->20 are normal BCD carries.
- **FSM states:**
  - SYNC, entered on reset: on a clean commit, load time_bcd, compute expected=succ(time), set valid=1, go to TRACK. No sequence check is made.
  - TRACK: on a clean commit, load time_bcd. If chk_en=1 and time != expected, pulse seq_err; valid stays 1. In every case expected <= succ(new time).
  - Any state, commit with a pattern error: pat_err pulses, time_bcd holds, valid<=0, go to SYNC.
  - Any state, commit with a range error: range_err pulses, time_bcd is loaded with the decoded value, valid<=0, go to SYNC.
  - A pattern error takes priority over a range error; only one error pulse is raised per commit.
  - Rising edge of chk_en (registered): go to SYNC, valid<=0. This rule takes priority over a same-cycle commit, which is then treated as SYNC's first commit.
- **Error counter:**
  - err_cnt increments by 1 per error pulse and saturates at all-ones.
  - It is cleared only by rst.
- **Update pulse:** upd pulses on every commit, including error commits.

## Timing
- Reset values:
  - time_bcd=0, valid=0, all pulses 0, err_cnt=0.
  - samp_q = all-ones, stab_cnt=0, state=SYNC, expected=0.
- Latency: if sev_seg changes before edge k and holds, the outputs update and pulse after edge k+STABLE_CYCLES. With the default of 4, that is 4 cycles.
- Glitch rule: a pattern held for fewer than STABLE_CYCLES+1 consecutive samples is never committed, and the previous commit stands.
- Pulses are exactly one cycle long. Back-to-back commits are impossible, because commits are at least STABLE_CYCLES+1 cycles apart.
- Asserting rst at any point overrides everything on the next edge, including mid-filter and mid-commit.

## Test plan
- **Reset and first commit:** rst for 2 cycles, then hold 12:34:56. Expect upd and valid after 4 cycles, time_bcd=0x123456, no errors.
- **Sequence and wrap:** chk_en=1, step through 23:59:58 -> 23:59:59 -> 00:00:00, holding each for 10 cycles. Expect three upd pulses, no seq_err, final time_bcd=0x000000.
- **Skip detection:** in TRACK, step 10:00:00 -> 10:00:02. Expect seq_err pulse and err_cnt=1. Then step to 10:00:03: expect no error.
- **Manual mode:** chk_en=0, step 10:00:00 -> 15:27:00. Expect no seq_err. Then raise chk_en and present 15:27:01: expect valid to drop, re-sync, and valid=1 with no seq_err.
- **Glitch and bad pattern:** a 3-cycle glitch on sec0 produces no upd. Holding sec0=0111111 produces pat_err, valid=0, time_bcd unchanged.
- **Range and saturation:** hold hr=25 to get range_err and valid=0. Force 300 alternating bad patterns: err_cnt saturates at 255.
